life_grid_ctrl: RTL and testbench
=================================

LIFE_GRID_CTRL -- requirements
Module: life_grid_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 8, grid columns (2..64).
REQ-002 SHALL have parameter GRID_H, default 8, grid rows (2..64).
REQ-003 SHALL have parameter WRAP, default 1; 1 = toroidal edges, 0 = cells outside grid are dead.
REQ-004 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd  input  3  opcode: 0 NOP, 1 WRITE, 2 READ, 3 STEP, 4 CLEAR; 5..7 treated as NOP.
REQ-010 SHALL have port adr_x  input  $clog2(GRID_W)  cell column for WRITE/READ.
REQ-011 SHALL have port adr_y  input  $clog2(GRID_H)  cell row for WRITE/READ.
REQ-012 SHALL have port state_in  input  1  value written by WRITE.
REQ-013 SHALL have port step_count  input  8  generations for STEP; 0 treated as 1.
REQ-014 SHALL have port halt  input  1  abort in-progress STEP.
REQ-015 SHALL have port state_out  output  1  registered READ data.
REQ-016 SHALL have port rd_valid  output  1  one-cycle pulse qualifying state_out.
REQ-017 SHALL have port busy  output  1  high while stepping.
REQ-018 SHALL have port generation  output  GEN_W  generations computed since reset/CLEAR.
REQ-019 SHALL have port alive_count  output  $clog2(GRID_W*GRID_H+1)  registered live-cell population.

Function
REQ-020 FSM SHALL have states IDLE and STEPPING; cmd_ready = 1 in IDLE, 0 in STEPPING.
REQ-021 WRITE accepted at edge N SHALL set cell(adr_x,adr_y)=state_in, visible from edge N+1; out-of-range address (x>=GRID_W or y>=GRID_H) ignored.
REQ-022 READ accepted at edge N SHALL drive state_out = cell value and rd_valid = 1 after edge N; out-of-range returns 0 with rd_valid = 1.
REQ-023 state_out SHALL hold its last value when rd_valid = 0.
REQ-024 CLEAR SHALL zero all cells and generation in one cycle; FSM stays IDLE.
REQ-025 STEP SHALL load remaining = max(step_count,1), go to STEPPING next edge, and compute one full generation per cycle in STEPPING.
REQ-026 Next-state rule: B3/S23 over 8 neighbours, all cells updated simultaneously from the previous generation.
REQ-027 WRAP=1: neighbour indices modulo GRID_W/GRID_H; WRAP=0: out-of-grid neighbours count 0.
REQ-028 Each computed generation SHALL increment generation by 1, wrapping 2^GEN_W-1 -> 0.
REQ-029 STEPPING SHALL return to IDLE on the edge computing the last generation; busy falls then; a STEP of N takes exactly N STEPPING cycles.
REQ-030 halt sampled high in STEPPING SHALL return to IDLE on that edge without computing a generation; halt ignored in IDLE.
REQ-031 alive_count SHALL reflect the cell array one cycle after any change.
REQ-032 cmd_valid with cmd_ready = 0 SHALL have no effect; commander must hold the command.

Reset
REQ-033 reset low SHALL asynchronously clear all cells, generation, alive_count, state_out, rd_valid, busy and force IDLE (cmd_ready = 1 after deassertion), including mid-STEP.
REQ-034 Reset deassertion SHALL be synchronised externally; block assumes it meets recovery timing.

Structure
REQ-035 Shared package life_pkg SHALL hold the opcode enum (cmd_e), FSM state enum and the B3/S23 rule constants.
REQ-036 Per-cell next-state logic SHALL be a sub-module life_cell_rule (8 neighbour inputs, current state, next state), instanced per cell via generate.

Verification
REQ-037 8x8 WRAP=1, WRITE blinker (3,2),(3,3),(3,4), STEP 1 -> cells (2,3),(3,3),(4,3) live, alive_count 3, generation 1.
REQ-038 Glider at top-left, WRAP=1, STEP 32 -> same glider shape shifted (+8,+8)≡ original position, generation 32, busy high exactly 32 cycles.
REQ-039 2x2 block at (0,0) WRAP=0, STEP 5 -> unchanged, alive_count 4; same with WRAP=1 at (7,7) spanning corners -> unchanged.
REQ-040 READ (7,7) after WRITE 1 -> rd_valid pulse, state_out 1; READ x=9 on GRID_W=10? n/a -> with GRID_W=6 READ x=7 -> state_out 0, WRITE x=7 -> alive_count unchanged.
REQ-041 STEP 200 then halt at cycle 10 -> generation 10, IDLE next cycle; reset low at cycle 5 of another STEP -> all outputs 0, cmd_ready 1.
REQ-042 GEN_W=4, STEP 17 on blinker -> generation 1 (wrapped), blinker phase vertical-to-horizontal.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and B3/S23 rule constants for the Life grid controller.
package life_pkg;

   typedef enum logic [2:0] {
      CmdNop   = 3'd0,
      CmdWrite = 3'd1,
      CmdRead  = 3'd2,
      CmdStep  = 3'd3,
      CmdClear = 3'd4
   } cmd_e;

   typedef enum logic [0:0] {
      StIdle,
      StStepping
   } state_e;

   localparam int unsigned NBR_N = 8;

   // Bit n set means a neighbour count of n produces a live cell.
   localparam logic [8:0] BIRTH_MASK   = 9'b0_0000_1000;
   localparam logic [8:0] SURVIVE_MASK = 9'b0_0000_1100;

   // Neighbour k offsets, row-major around the centre cell.
   function automatic int nbr_dx(input int k);
      case (k)
         0, 3, 5: return -1;
         1, 6:    return 0;
         default: return 1;
      endcase
   endfunction

   function automatic int nbr_dy(input int k);
      case (k)
         0, 1, 2: return -1;
         3, 4:    return 0;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state function of a single Life cell from its eight neighbours.
module life_cell_rule
   import life_pkg::*;
(
   input  logic [NBR_N-1:0] nbrs,
   input  logic             cur,
   output logic             nxt
);

   logic [3:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NBR_N; i++) begin
         cnt = cnt + {3'b000, nbrs[i]};
      end
      nxt = cur ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
   end

endmodule

// File: rtl/life_grid_ctrl.sv
// Conway Life grid with a command port for cell access, clearing and multi-generation stepping.
module life_grid_ctrl
   import life_pkg::*;
#(
   parameter int unsigned GRID_W = 8,
   parameter int unsigned GRID_H = 8,
   parameter int unsigned WRAP   = 1,
   parameter int unsigned GEN_W  = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [2:0]                           cmd,
   input  logic [$clog2(GRID_W)-1:0]            adr_x,
   input  logic [$clog2(GRID_H)-1:0]            adr_y,
   input  logic                                 state_in,
   input  logic [7:0]                           step_count,
   input  logic                                 halt,
   output logic                                 state_out,
   output logic                                 rd_valid,
   output logic                                 busy,
   output logic [GEN_W-1:0]                     generation,
   output logic [$clog2(GRID_W*GRID_H+1)-1:0]   alive_count
);

   localparam int unsigned CW = $clog2(GRID_W * GRID_H + 1);
   localparam int GW = int'(GRID_W);
   localparam int GH = int'(GRID_H);

   logic [GRID_H-1:0][GRID_W-1:0] cells_q, cells_d, cells_nxt;
   state_e                        st_q, st_d;
   cmd_e                          cmd_op;
   logic [7:0]                    rem_q, rem_d;
   logic [GEN_W-1:0]              gen_q, gen_d;
   logic [CW-1:0]                 alive_q, alive_d;
   logic                          rdv_q, rdv_d;
   logic                          rdo_q, rdo_d;
   logic                          adr_ok;

   assign cmd_op = cmd_e'(cmd);
   assign adr_ok = (32'(adr_x) < GRID_W) && (32'(adr_y) < GRID_H);

   for (genvar y = 0; y < GH; y++) begin : g_row
      for (genvar x = 0; x < GW; x++) begin : g_col
         logic [NBR_N-1:0] nbrs;
         for (genvar k = 0; k < NBR_N; k++) begin : g_nbr
            localparam int NX = x + nbr_dx(k);
            localparam int NY = y + nbr_dy(k);
            localparam int WX = (NX + GW) % GW;
            localparam int WY = (NY + GH) % GH;
            // Without wrap, neighbours beyond the edge read as dead.
            if (WRAP != 0 || (NX >= 0 && NX < GW && NY >= 0 && NY < GH)) begin : g_in
               assign nbrs[k] = cells_q[WY][WX];
            end else begin : g_out
               assign nbrs[k] = 1'b0;
            end
         end
         life_cell_rule u_rule (
            .nbrs (nbrs),
            .cur  (cells_q[y][x]),
            .nxt  (cells_nxt[y][x])
         );
      end
   end

   always_comb begin
      alive_d = '0;
      for (int y = 0; y < GH; y++) begin
         for (int x = 0; x < GW; x++) begin
            alive_d = alive_d + CW'(cells_q[y][x]);
         end
      end
   end

   always_comb begin
      st_d    = st_q;
      rem_d   = rem_q;
      gen_d   = gen_q;
      cells_d = cells_q;
      rdv_d   = 1'b0;
      rdo_d   = rdo_q;
      case (st_q)
         StIdle: begin
            if (cmd_valid) begin
               case (cmd_op)
                  CmdWrite: begin
                     if (adr_ok) cells_d[adr_y][adr_x] = state_in;
                  end
                  CmdRead: begin
                     rdv_d = 1'b1;
                     rdo_d = adr_ok ? cells_q[adr_y][adr_x] : 1'b0;
                  end
                  CmdStep: begin
                     rem_d = (step_count == 8'd0) ? 8'd1 : step_count;
                     st_d  = StStepping;
                  end
                  CmdClear: begin
                     cells_d = '0;
                     gen_d   = '0;
                  end
                  default: ;
               endcase
            end
         end
         StStepping: begin
            if (halt) begin
               st_d = StIdle;
            end else begin
               cells_d = cells_nxt;
               gen_d   = gen_q + GEN_W'(1);
               rem_d   = rem_q - 8'd1;
               if (rem_q == 8'd1) st_d = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= StIdle;
         rem_q   <= '0;
         gen_q   <= '0;
         cells_q <= '0;
         alive_q <= '0;
         rdv_q   <= 1'b0;
         rdo_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         rem_q   <= rem_d;
         gen_q   <= gen_d;
         cells_q <= cells_d;
         alive_q <= alive_d;
         rdv_q   <= rdv_d;
         rdo_q   <= rdo_d;
      end
   end

   assign cmd_ready   = (st_q == StIdle);
   assign busy        = (st_q == StStepping);
   assign state_out   = rdo_q;
   assign rd_valid    = rdv_q;
   assign generation  = gen_q;
   assign alive_count = alive_q;

endmodule

// File: tb/tb_life_grid_ctrl.sv
// Directed bench: an 8x8 toroidal grid (A) and a 6x8 bounded grid with 4-bit generation (B).
module tb_life_grid_ctrl;

   localparam logic [2:0] C_NOP = 3'd0;
   localparam logic [2:0] C_WR  = 3'd1;
   localparam logic [2:0] C_RD  = 3'd2;
   localparam logic [2:0] C_ST  = 3'd3;
   localparam logic [2:0] C_CLR = 3'd4;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [2:0] adr_x, adr_y;
   logic       state_in;
   logic [7:0] step_count;
   logic       halt;

   logic        a_cmd_ready, a_state_out, a_rd_valid, a_busy;
   logic [15:0] a_gen;
   logic [6:0]  a_alive;
   logic        b_cmd_ready, b_state_out, b_rd_valid, b_busy;
   logic [3:0]  b_gen;
   logic [5:0]  b_alive;

   life_grid_ctrl #(.GRID_W(8), .GRID_H(8), .WRAP(1), .GEN_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd(cmd),
      .adr_x(adr_x), .adr_y(adr_y), .state_in(state_in), .step_count(step_count), .halt(halt),
      .state_out(a_state_out), .rd_valid(a_rd_valid), .busy(a_busy), .generation(a_gen),
      .alive_count(a_alive)
   );

   life_grid_ctrl #(.GRID_W(6), .GRID_H(8), .WRAP(0), .GEN_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd(cmd),
      .adr_x(adr_x), .adr_y(adr_y), .state_in(state_in), .step_count(step_count), .halt(halt),
      .state_out(b_state_out), .rd_valid(b_rd_valid), .busy(b_busy), .generation(b_gen),
      .alive_count(b_alive)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [2:0] cmd;
      int         x;
      int         y;
      logic       din;
      int         stepn;
      bit         on_b;
      int         exp_out;
      int         exp_alive;
      int         exp_gen;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] c, input int x, input int y, input logic d,
                               input int n, input bit b, input int eo, input int ea,
                               input int eg);
      vec_t r;
      r.cmd = c; r.x = x; r.y = y; r.din = d; r.stepn = n; r.on_b = b;
      r.exp_out = eo; r.exp_alive = ea; r.exp_gen = eg;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic send(input logic [2:0] c, input int x, input int y, input logic d,
                       input int n);
      @(negedge clk);
      cmd = c; adr_x = 3'(x); adr_y = 3'(y); state_in = d; step_count = 8'(n);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd = C_NOP;
   endtask

   task automatic apply(input int idx, input vec_t v);
      string tag;
      int    cyc;
      tag = $sformatf("vec%0d", idx);
      send(v.cmd, v.x, v.y, v.din, v.stepn);
      check({tag, ".rd_valid"}, v.on_b ? int'(b_rd_valid) : int'(a_rd_valid),
            (v.cmd == C_RD) ? 1 : 0);
      if (v.cmd == C_RD)
         check({tag, ".state_out"}, v.on_b ? int'(b_state_out) : int'(a_state_out), v.exp_out);
      if (v.cmd == C_ST) begin
         cyc = 0;
         while ((v.on_b ? b_busy : a_busy) && cyc < 1000) begin
            cyc++;
            @(negedge clk);
         end
         check({tag, ".busy_cycles"}, cyc, (v.stepn == 0) ? 1 : v.stepn);
      end
      @(negedge clk);
      check({tag, ".alive"}, v.on_b ? int'(b_alive) : int'(a_alive), v.exp_alive);
      check({tag, ".gen"}, v.on_b ? int'(b_gen) : int'(a_gen), v.exp_gen);
   endtask

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd = C_NOP; adr_x = '0; adr_y = '0;
      state_in = 1'b0; step_count = '0; halt = 1'b0;

      // A: blinker, STEP 0 as 1, corner-spanning block, glider round trip
      tbl.push_back(mk(C_CLR, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(C_WR,  3, 2, 1, 0,  0, 0, 1, 0));
      tbl.push_back(mk(C_WR,  3, 3, 1, 0,  0, 0, 2, 0));
      tbl.push_back(mk(C_WR,  3, 4, 1, 0,  0, 0, 3, 0));
      tbl.push_back(mk(C_RD,  3, 3, 0, 0,  0, 1, 3, 0));
      tbl.push_back(mk(C_ST,  0, 0, 0, 1,  0, 0, 3, 1));
      tbl.push_back(mk(C_RD,  2, 3, 0, 0,  0, 1, 3, 1));
      tbl.push_back(mk(C_RD,  3, 2, 0, 0,  0, 0, 3, 1));
      tbl.push_back(mk(C_RD,  4, 3, 0, 0,  0, 1, 3, 1));
      tbl.push_back(mk(C_ST,  0, 0, 0, 0,  0, 0, 3, 2));
      tbl.push_back(mk(C_RD,  3, 4, 0, 0,  0, 1, 3, 2));
      tbl.push_back(mk(C_RD,  7, 7, 0, 0,  0, 0, 3, 2));
      tbl.push_back(mk(C_WR,  7, 7, 1, 0,  0, 0, 4, 2));
      tbl.push_back(mk(C_RD,  7, 7, 0, 0,  0, 1, 4, 2));
      tbl.push_back(mk(C_WR,  7, 7, 0, 0,  0, 0, 3, 2));
      tbl.push_back(mk(C_CLR, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(C_WR,  7, 7, 1, 0,  0, 0, 1, 0));
      tbl.push_back(mk(C_WR,  0, 7, 1, 0,  0, 0, 2, 0));
      tbl.push_back(mk(C_WR,  7, 0, 1, 0,  0, 0, 3, 0));
      tbl.push_back(mk(C_WR,  0, 0, 1, 0,  0, 0, 4, 0));
      tbl.push_back(mk(C_ST,  0, 0, 0, 5,  0, 0, 4, 5));
      tbl.push_back(mk(C_RD,  0, 0, 0, 0,  0, 1, 4, 5));
      tbl.push_back(mk(C_RD,  7, 0, 0, 0,  0, 1, 4, 5));
      tbl.push_back(mk(C_RD,  1, 1, 0, 0,  0, 0, 4, 5));
      tbl.push_back(mk(C_CLR, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(C_WR,  1, 0, 1, 0,  0, 0, 1, 0));
      tbl.push_back(mk(C_WR,  2, 1, 1, 0,  0, 0, 2, 0));
      tbl.push_back(mk(C_WR,  0, 2, 1, 0,  0, 0, 3, 0));
      tbl.push_back(mk(C_WR,  1, 2, 1, 0,  0, 0, 4, 0));
      tbl.push_back(mk(C_WR,  2, 2, 1, 0,  0, 0, 5, 0));
      tbl.push_back(mk(C_ST,  0, 0, 0, 32, 0, 0, 5, 32));
      tbl.push_back(mk(C_RD,  1, 0, 0, 0,  0, 1, 5, 32));
      tbl.push_back(mk(C_RD,  2, 1, 0, 0,  0, 1, 5, 32));
      tbl.push_back(mk(C_RD,  0, 2, 0, 0,  0, 1, 5, 32));
      tbl.push_back(mk(C_RD,  1, 2, 0, 0,  0, 1, 5, 32));
      tbl.push_back(mk(C_RD,  2, 2, 0, 0,  0, 1, 5, 32));
      tbl.push_back(mk(C_RD,  1, 1, 0, 0,  0, 0, 5, 32));
      // B: bounded block, out-of-range access, generation wrap on a blinker
      tbl.push_back(mk(C_CLR, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(C_WR,  0, 0, 1, 0,  1, 0, 1, 0));
      tbl.push_back(mk(C_WR,  1, 0, 1, 0,  1, 0, 2, 0));
      tbl.push_back(mk(C_WR,  0, 1, 1, 0,  1, 0, 3, 0));
      tbl.push_back(mk(C_WR,  1, 1, 1, 0,  1, 0, 4, 0));
      tbl.push_back(mk(C_ST,  0, 0, 0, 5,  1, 0, 4, 5));
      tbl.push_back(mk(C_RD,  0, 0, 0, 0,  1, 1, 4, 5));
      tbl.push_back(mk(C_RD,  7, 0, 0, 0,  1, 0, 4, 5));
      tbl.push_back(mk(C_WR,  7, 0, 1, 0,  1, 0, 4, 5));
      tbl.push_back(mk(C_RD,  2, 2, 0, 0,  1, 0, 4, 5));
      tbl.push_back(mk(C_CLR, 0, 0, 0, 0,  1, 0, 0, 0));
      tbl.push_back(mk(C_WR,  2, 2, 1, 0,  1, 0, 1, 0));
      tbl.push_back(mk(C_WR,  2, 3, 1, 0,  1, 0, 2, 0));
      tbl.push_back(mk(C_WR,  2, 4, 1, 0,  1, 0, 3, 0));
      tbl.push_back(mk(C_ST,  0, 0, 0, 17, 1, 0, 3, 1));
      tbl.push_back(mk(C_RD,  1, 3, 0, 0,  1, 1, 3, 1));
      tbl.push_back(mk(C_RD,  3, 3, 0, 0,  1, 1, 3, 1));
      tbl.push_back(mk(C_RD,  2, 2, 0, 0,  1, 0, 3, 1));
      tbl.push_back(mk(C_RD,  2, 4, 0, 0,  1, 0, 3, 1));

      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst.a_cmd_ready", int'(a_cmd_ready), 1);
      check("rst.a_busy", int'(a_busy), 0);
      check("rst.a_gen", int'(a_gen), 0);
      check("rst.a_alive", int'(a_alive), 0);
      check("rst.a_rd_valid", int'(a_rd_valid), 0);
      check("rst.a_state_out", int'(a_state_out), 0);
      check("rst.b_cmd_ready", int'(b_cmd_ready), 1);
      check("rst.b_gen", int'(b_gen), 0);

      foreach (tbl[i]) apply(i, tbl[i]);

      // state_out holds after the rd_valid pulse
      send(C_RD, 1, 3, 1'b0, 0);
      check("hold.rd_valid_pulse", int'(b_rd_valid), 1);
      check("hold.state_out_pulse", int'(b_state_out), 1);
      @(negedge clk);
      check("hold.rd_valid_low", int'(b_rd_valid), 0);
      check("hold.state_out_kept", int'(b_state_out), 1);

      // halt after 10 generations; a CLEAR offered while busy must be ignored
      send(C_CLR, 0, 0, 1'b0, 0);
      send(C_ST, 0, 0, 1'b0, 200);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 2) begin
            cmd = C_CLR;
            cmd_valid = 1'b1;
         end
         if (i == 3) check("halt.cmd_ready_busy", int'(a_cmd_ready), 0);
         if (i == 7) begin
            cmd_valid = 1'b0;
            cmd = C_NOP;
         end
      end
      check("halt.gen_before", int'(a_gen), 10);
      check("halt.busy_before", int'(a_busy), 1);
      halt = 1'b1;
      @(negedge clk);
      check("halt.busy_after", int'(a_busy), 0);
      check("halt.cmd_ready_after", int'(a_cmd_ready), 1);
      check("halt.gen_after", int'(a_gen), 10);
      // halt still high while idle and at STEP acceptance has no effect
      send(C_ST, 0, 0, 1'b0, 2);
      halt = 1'b0;
      check("halt.idle_ignored", int'(a_busy), 1);
      repeat (2) @(negedge clk);
      check("halt.step2_gen", int'(a_gen), 12);
      check("halt.step2_busy", int'(a_busy), 0);

      // asynchronous reset in the middle of a STEP
      send(C_CLR, 0, 0, 1'b0, 0);
      send(C_WR, 2, 2, 1'b1, 0);
      send(C_WR, 3, 2, 1'b1, 0);
      send(C_WR, 2, 3, 1'b1, 0);
      send(C_WR, 3, 3, 1'b1, 0);
      send(C_RD, 2, 2, 1'b0, 0);
      check("mid.read_live", int'(a_state_out), 1);
      send(C_ST, 0, 0, 1'b0, 50);
      repeat (5) @(negedge clk);
      check("mid.gen5", int'(a_gen), 5);
      check("mid.busy", int'(a_busy), 1);
      check("mid.alive", int'(a_alive), 4);
      reset = 1'b0;
      #1;
      check("arst.a_busy", int'(a_busy), 0);
      check("arst.a_gen", int'(a_gen), 0);
      check("arst.a_alive", int'(a_alive), 0);
      check("arst.a_state_out", int'(a_state_out), 0);
      check("arst.a_rd_valid", int'(a_rd_valid), 0);
      check("arst.a_cmd_ready", int'(a_cmd_ready), 1);
      check("arst.b_busy", int'(b_busy), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("arst.ready_after", int'(a_cmd_ready), 1);
      check("arst.idle_after", int'(a_busy), 0);
      send(C_RD, 2, 2, 1'b0, 0);
      check("arst.cell_cleared_rdv", int'(a_rd_valid), 1);
      check("arst.cell_cleared", int'(a_state_out), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
